// File: rtl/step_sequencer_pkg.sv
// Shared types and defaults for the step sequencer.
// The FSM encoding and the width of one stored pattern entry live here.
package step_sequencer_pkg;

    localparam int NUM_STEPS_DEF = 16;
    localparam int NOTE_W_DEF    = 6;
    localparam int ENTRY_W       = NOTE_W_DEF + 1;
    localparam int GCNT_W        = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } seq_state_e;

    // Step count actually cycled through: 0 or out-of-range means "all steps".
    function automatic int eff_len(input int len, input int steps);
        return (len == 0 || len > steps) ? steps : len;
    endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control, pattern-write and playback signals of the step sequencer.
// master drives tempo/run/pattern writes, slave is the sequencer itself.
interface step_sequencer_if #(
    parameter int NOTE_W = 6,
    parameter int IDX_W  = 4
);
    logic              variableClk;
    logic              run;
    logic [IDX_W:0]    seq_len;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [NOTE_W-1:0] wr_note;
    logic              wr_gate;
    logic [NOTE_W-1:0] note;
    logic              gate;
    logic [IDX_W-1:0]  cur_step;
    logic              step_pulse;

    modport master (
        output variableClk, run, seq_len,
        output wr_en, wr_addr, wr_note, wr_gate,
        input  note, gate, cur_step, step_pulse
    );

    modport slave (
        input  variableClk, run, seq_len,
        input  wr_en, wr_addr, wr_note, wr_gate,
        output note, gate, cur_step, step_pulse
    );
endinterface

// File: rtl/step_sequencer_pattern_ram.sv
// Pattern store: one write port, one combinational read port, async clear.
// A same-cycle write and read of one address returns the old contents.
module seq_pattern_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/step_sequencer.sv
// Tempo-driven step sequencer: plays stored notes on each variableClk
// rising edge while running, with a fixed-length gate per enabled step.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEF,
    parameter int NOTE_W    = NOTE_W_DEF,
    parameter int GATE_LEN  = 5
) (
    input  logic clk100hz,
    input  logic reset,
    step_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam int LEN_W = IDX_W + 1;

    seq_state_e        state_q;
    logic [IDX_W-1:0]  step_q;
    logic [IDX_W-1:0]  step_d;
    logic [IDX_W-1:0]  cur_q;
    logic [NOTE_W-1:0] note_q;
    logic              gate_q;
    logic              pulse_q;
    logic [GCNT_W-1:0] gcnt_q;
    logic              vclk_q;

    logic              tick;
    logic              wrap;
    logic [LEN_W-1:0]  len_eff;
    logic [NOTE_W:0]   rd_data;

    seq_pattern_ram #(
        .DEPTH (NUM_STEPS),
        .W     (NOTE_W + 1)
    ) u_ram (
        .clk_i   (clk100hz),
        .rst_i   (reset),
        .we_i    (bus.wr_en),
        .waddr_i (bus.wr_addr),
        .wdata_i ({bus.wr_gate, bus.wr_note}),
        .raddr_i (step_q),
        .rdata_o (rd_data)
    );

    assign tick = bus.variableClk & ~vclk_q;

    // Wrap test is ">=" so a shrunken length never leaves step_q out of range.
    always_comb begin
        len_eff = LEN_W'(eff_len(int'(bus.seq_len), NUM_STEPS));
        wrap    = {1'b0, step_q} >= (len_eff - LEN_W'(1));
        step_d  = wrap ? '0 : step_q + IDX_W'(1);
    end

    always_ff @(posedge clk100hz or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cur_q   <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            pulse_q <= 1'b0;
            gcnt_q  <= '0;
            vclk_q  <= 1'b0;
        end else begin
            vclk_q  <= bus.variableClk;
            pulse_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.run) state_q <= S_PLAY;
                end
                S_PLAY: begin
                    if (!bus.run) begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                        gate_q  <= 1'b0;
                        gcnt_q  <= '0;
                    end else if (tick) begin
                        note_q  <= rd_data[NOTE_W-1:0];
                        gate_q  <= rd_data[NOTE_W];
                        cur_q   <= step_q;
                        pulse_q <= 1'b1;
                        gcnt_q  <= GCNT_W'(GATE_LEN);
                        step_q  <= step_d;
                    end else if (gcnt_q != '0) begin
                        gcnt_q <= gcnt_q - GCNT_W'(1);
                        if (gcnt_q == GCNT_W'(1)) gate_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.note       = note_q;
    assign bus.gate       = gate_q;
    assign bus.cur_step   = cur_q;
    assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: random and directed stimulus against a
// behavioural playback model, plus literal expectations for key scenarios.
module tb_step_sequencer;

  localparam int GL = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  step_sequencer_if #(.NOTE_W(6), .IDX_W(4)) bus ();

  step_sequencer #(
    .NUM_STEPS (16),
    .NOTE_W    (6),
    .GATE_LEN  (GL)
  ) dut (
    .clk100hz (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int compared = 0;
  int mismatched = 0;
  bit chk_on = 1'b0;

  // behavioural model state
  int m_note [16];
  bit m_gate [16];
  bit m_play;
  int m_pos;
  bit m_pvclk;
  int e_note, e_step;
  bit e_pulse;
  int edges, last_edge;
  bit last_gate;

  // logs of what the DUT played
  int lg_note [$];
  int lg_step [$];
  bit lg_gate [$];
  int runs [$];
  int gate_run = 0;

  function automatic bit e_gate();
    return last_gate && ((edges - last_edge) < GL);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_note[i] = 0;
        m_gate[i] = 1'b0;
      end
      m_play = 1'b0; m_pos = 0; m_pvclk = 1'b0;
      e_note = 0; e_step = 0; e_pulse = 1'b0;
      edges = 0; last_edge = 0; last_gate = 1'b0;
    end else begin
      bit tk;
      int len;
      edges++;
      tk = bus.variableClk && !m_pvclk;
      m_pvclk = bus.variableClk;
      e_pulse = 1'b0;
      if (!m_play) begin
        if (bus.run) m_play = 1'b1;
      end else if (!bus.run) begin
        m_play = 1'b0;
        m_pos = 0;
        last_gate = 1'b0;
      end else if (tk) begin
        e_note = m_note[m_pos];
        e_step = m_pos;
        e_pulse = 1'b1;
        last_gate = m_gate[m_pos];
        last_edge = edges;
        len = int'(bus.seq_len);
        if (len == 0 || len > 16) len = 16;
        m_pos = (m_pos + 1 >= len) ? 0 : m_pos + 1;
      end
      if (bus.wr_en) begin
        m_note[bus.wr_addr] = int'(bus.wr_note);
        m_gate[bus.wr_addr] = bus.wr_gate;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      logic [11:0] act, expv;
      act = {bus.note, bus.gate, bus.cur_step, bus.step_pulse};
      expv = {6'(e_note), e_gate(), 4'(e_step), e_pulse};
      compared++;
      if (act !== expv) begin
        mismatched++;
        $display("FAIL cycle t=%0t: got note=%0d gate=%0b step=%0d pulse=%0b, want note=%0d gate=%0b step=%0d pulse=%0b",
                 $time, bus.note, bus.gate, bus.cur_step, bus.step_pulse,
                 e_note, e_gate(), e_step, e_pulse);
      end
      if (bus.step_pulse) begin
        lg_note.push_back(int'(bus.note));
        lg_step.push_back(int'(bus.cur_step));
        lg_gate.push_back(bus.gate);
      end
      if (bus.gate) gate_run++;
      else if (gate_run != 0) begin
        runs.push_back(gate_run);
        gate_run = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int n, input bit g);
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_note = 6'(n);
    bus.wr_gate = g;
    step(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic tick(input int gap);
    bus.variableClk = 1'b1;
    step(1);
    bus.variableClk = 1'b0;
    step(gap - 1);
  endtask

  initial begin
    int en [6];
    int es [6];
    int n0;
    en = '{10, 11, 12, 13, 10, 11};
    es = '{0, 1, 2, 3, 0, 1};
    bus.variableClk = 1'b0;
    bus.run = 1'b0;
    bus.seq_len = 5'd4;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_note = '0;
    bus.wr_gate = 1'b0;
    #1 rst = 1'b1;
    step(3);
    chk("rst_note", int'(bus.note), 0);
    chk("rst_gate", int'(bus.gate), 0);
    chk("rst_step", int'(bus.cur_step), 0);
    chk("rst_pulse", int'(bus.step_pulse), 0);
    rst = 1'b0;
    chk_on = 1'b1;

    for (int a = 0; a < 4; a++) wr(a, 10 + a, 1'b1);
    bus.run = 1'b1;
    step(2);
    for (int i = 0; i < 6; i++) tick(20);
    chk("six_pulses", lg_note.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("note%0d", i), lg_note[i], en[i]);
      chk($sformatf("step%0d", i), lg_step[i], es[i]);
    end
    chk("gate_runs", runs.size(), 6);
    chk("gate_len", runs[0], GL);

    wr(2, 12, 1'b0);
    tick(20);
    chk("dis_pulse", lg_note.size(), 7);
    chk("dis_step", lg_step[$], 2);
    chk("dis_gate", int'(lg_gate[$]), 0);

    n0 = lg_note.size();
    bus.variableClk = 1'b1;
    step(50);
    bus.variableClk = 1'b0;
    step(5);
    chk("held_one_tick", lg_note.size(), n0 + 1);

    wr(2, 12, 1'b1);
    tick(10);
    tick(10);
    tick(2);
    chk("gate_pre_stop", int'(bus.gate), 1);
    bus.run = 1'b0;
    step(1);
    chk("gate_stop", int'(bus.gate), 0);
    n0 = lg_note.size();
    tick(5);
    tick(5);
    chk("idle_ignored", lg_note.size(), n0);
    bus.run = 1'b1;
    step(2);
    tick(10);
    chk("restart_step", lg_step[$], 0);

    bus.seq_len = 5'd0;
    repeat (16) tick(3);
    chk("len0_15", lg_step[lg_step.size() - 2], 15);
    chk("len0_0", lg_step[$], 0);
    bus.seq_len = 5'd20;
    repeat (16) tick(3);
    chk("len20_15", lg_step[lg_step.size() - 2], 15);
    chk("len20_0", lg_step[$], 0);

    bus.seq_len = 5'd4;
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'd1;
    bus.wr_note = 6'd40;
    bus.wr_gate = 1'b1;
    bus.variableClk = 1'b1;
    step(1);
    bus.wr_en = 1'b0;
    bus.variableClk = 1'b0;
    step(4);
    chk("rw_old", lg_note[$], 11);
    repeat (4) tick(5);
    chk("rw_new", lg_note[$], 40);
    chk("rw_new_step", lg_step[$], 1);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(149) == 0) bus.run = ~bus.run;
      if ($urandom_range(299) == 0) bus.seq_len = 5'($urandom_range(31));
      if ($urandom_range(5) == 0) bus.variableClk = ~bus.variableClk;
      bus.wr_en = ($urandom_range(7) == 0);
      bus.wr_addr = 4'($urandom_range(15));
      bus.wr_note = 6'($urandom_range(63));
      bus.wr_gate = 1'($urandom_range(1));
      step(1);
    end
    bus.wr_en = 1'b0;
    bus.variableClk = 1'b0;

    bus.run = 1'b1;
    bus.seq_len = 5'd4;
    for (int a = 0; a < 4; a++) wr(a, 33 + a, 1'b1);
    step(3);
    tick(2);
    chk("pre_rst_gate", int'(bus.gate), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_note", int'(bus.note), 0);
    chk("abort_gate", int'(bus.gate), 0);
    chk("abort_step", int'(bus.cur_step), 0);
    chk("abort_pulse", int'(bus.step_pulse), 0);
    n0 = lg_note.size();
    bus.variableClk = 1'b1;
    step(2);
    rst = 1'b0;
    step(10);
    bus.variableClk = 1'b0;
    step(5);
    chk("post_rst_ignored", lg_note.size(), n0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 16, pattern memory depth (power of two).
REQ-002 SHALL have parameter NOTE_W, default 6, note-number width.
REQ-003 SHALL have parameter GATE_LEN, default 5, gate-high duration in clk100hz cycles (legal range 1..255).
REQ-004 SHALL have port clk100hz  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port variableClk  input  1  tempo clock from the variable clock stage, synchronous to clk100hz; each rising edge is one step tick.
REQ-007 SHALL have port run  input  1  level; 1 = play, 0 = stop.
REQ-008 SHALL have port seq_len  input  5  active step count.
REQ-009 SHALL have port wr_en  input  1  pattern write strobe.
REQ-010 SHALL have port wr_addr  input  4  pattern write address.
REQ-011 SHALL have port wr_note  input  NOTE_W  note to store.
REQ-012 SHALL have port wr_gate  input  1  step-enabled bit to store.
REQ-013 SHALL have port note  output  NOTE_W  note of the step being played.
REQ-014 SHALL have port gate  output  1  note-on gate.
REQ-015 SHALL have port cur_step  output  4  index of the step being played.
REQ-016 SHALL have port step_pulse  output  1  one-cycle strobe per played step.

Function
REQ-017 Tick detection: register variableClk once; tick = variableClk & ~variableClk_q; level held high produces exactly one tick.
REQ-018 FSM states IDLE and PLAY; IDLE->PLAY when run=1; PLAY->IDLE when run=0; transition takes one cycle.
REQ-019 Ticks SHALL be ignored in IDLE and in any cycle where run=0.
REQ-020 On tick in PLAY (cycle N), at end of cycle N: note<=mem[step_idx].note, gate<=mem[step_idx].gate, cur_step<=step_idx, step_pulse<=1, gate counter<=GATE_LEN; outputs visible in cycle N+1 (latency 1 cycle).
REQ-021 step_idx SHALL advance on each played tick; wraps to 0 when step_idx >= eff_len-1.
REQ-022 eff_len = 16 when seq_len is 0 or >16, else seq_len; if seq_len shrinks below step_idx+1, next tick plays step_idx then wraps, no out-of-range read after that.
REQ-023 gate SHALL fall after exactly GATE_LEN cycles high, or stay high only if a new tick with enabled step reloads it; a tick on a disabled step drives gate 0 in N+1.
REQ-024 step_pulse SHALL be high exactly one cycle per played tick, regardless of step gate bit.
REQ-025 Entering IDLE: step_idx<=0, gate<=0 in same cycle as transition; note and cur_step hold.
REQ-026 Pattern write: wr_en=1 writes {wr_gate,wr_note} to mem[wr_addr] at end of cycle; writes allowed in both states.
REQ-027 Write and tick-read of same address in same cycle: read returns old contents.

Reset
REQ-028 On reset=1, asynchronously: state IDLE, step_idx 0, cur_step 0, note 0, gate 0, step_pulse 0, gate counter 0, variableClk_q 0, all mem entries 0.
REQ-029 Reset asserted mid-PLAY SHALL abort immediately; after release, first tick is ignored unless run=1 and state is PLAY.

Structure
REQ-030 State encoding, NOTE_W/NUM_STEPS defaults and the step-entry record width SHALL live in a shared sequencer package.
REQ-031 Pattern memory SHALL be one sub-module, seq_pattern_ram (1 write port, 1 async read port, async clear).

Verification
REQ-032 Reset, write mem[0..3]={gate1,note 10,11,12,13}, seq_len=4, run=1, 6 ticks -> notes 10,11,12,13,10,11; step_pulse 6 single-cycle pulses; cur_step 0,1,2,3,0,1.
REQ-033 GATE_LEN=5, ticks 20 cycles apart -> gate high exactly 5 cycles after each tick+1; mem[2] gate bit 0 -> gate stays 0 for step 2, step_pulse still fires.
REQ-034 variableClk held high 50 cycles -> exactly one tick; seq_len=0 and seq_len=20 -> 16-step wrap (cur_step 15 then 0).
REQ-035 run=0 at step 2 with gate high -> gate 0 next cycle, ticks ignored; run=1 again -> first tick plays step 0.
REQ-036 Write mem[1] note 40 in same cycle as tick reading step 1 (old note 11) -> note 11 played; next lap plays 40; reset asserted mid-PLAY -> all outputs 0 asynchronously.
